// File: rtl/stream_arbiter.sv
// Round-robin arbiter that merges NUM_REQ valid/ready streams into one
// registered output slot. All state advances on the falling clock edge.
module stream_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                         clock,
  input  logic                         nreset,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(NUM_REQ)-1:0]   out_id,
  input  logic                         out_ready
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e         state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     rrPtr_q, rrPtr_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grantId;
  logic [ID_W-1:0]     cand;
  logic                found;
  logic [DATA_W-1:0]   grantData;
  logic                slotFree;
  logic                upXfer;
  logic                downXfer;

  // Round-robin search: first valid requester starting at rrPtr_q, wrapping at NUM_REQ.
  always_comb begin
    grant   = '0;
    grantId = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rrPtr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        grant[cand] = 1'b1;
        grantId     = cand;
        found       = 1'b1;
      end
    end
  end

  // Payload mux driven by the one-hot grant so ready never looks at data.
  always_comb begin
    grantData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grantData = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign slotFree  = (!out_valid || out_ready) && !flush && nreset;
  assign req_ready = grant & {NUM_REQ{slotFree}};
  assign upXfer    = |req_ready;
  assign downXfer  = out_valid && out_ready;

  // Slot next-state: flush empties, a new upstream beat replaces, a drained beat empties.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    rrPtr_d = rrPtr_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (upXfer) begin
      state_d = FULL;
      data_d  = grantData;
      id_d    = grantId;
      rrPtr_d = (grantId == LAST_ID) ? '0 : grantId + 1'b1;
    end else if (downXfer) begin
      state_d = EMPTY;
    end
  end

  // State registers on the falling edge with synchronous active-low reset.
  always_ff @(negedge clock) begin
    if (!nreset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      rrPtr_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      rrPtr_q <= rrPtr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: a two-requester instance driven from a
// vector table, and a three-requester instance exercising the pointer wrap.
module tb_stream_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Two-requester instance
  logic        nresetA, flushA, outReadyA, outValidA;
  logic [1:0]  reqValidA, reqReadyA;
  logic [15:0] reqDataA;
  logic [7:0]  outDataA;
  logic [0:0]  outIdA;

  // Three-requester instance
  logic        nresetB, flushB, outReadyB, outValidB;
  logic [2:0]  reqValidB, reqReadyB;
  logic [23:0] reqDataB;
  logic [7:0]  outDataB;
  logic [1:0]  outIdB;

  int checks = 0;
  int errors = 0;

  stream_arbiter #(.NUM_REQ(2), .DATA_W(8)) dutA (
    .clock(clock), .nreset(nresetA), .flush(flushA),
    .req_valid(reqValidA), .req_data(reqDataA), .req_ready(reqReadyA),
    .out_valid(outValidA), .out_data(outDataA), .out_id(outIdA),
    .out_ready(outReadyA)
  );

  stream_arbiter #(.NUM_REQ(3), .DATA_W(8)) dutB (
    .clock(clock), .nreset(nresetB), .flush(flushB),
    .req_valid(reqValidB), .req_data(reqDataB), .req_ready(reqReadyB),
    .out_valid(outValidB), .out_data(outDataB), .out_id(outIdB),
    .out_ready(outReadyB)
  );

  typedef struct {
    logic       nrst;
    logic       fl;
    logic [1:0] rv;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ordy;
    logic [1:0] expRdy;
    logic       expV;
    logic [7:0] expD;
    logic       expId;
  } vec_t;

  vec_t vecs [23];

  // Compare one value and log a failure line when it differs.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one row on the rising edge, check ready, then check the slot after the falling edge.
  task automatic applyStimulus(input int idx, input vec_t v);
    @(posedge clock);
    nresetA   = v.nrst;
    flushA    = v.fl;
    reqValidA = v.rv;
    reqDataA  = {v.d1, v.d0};
    outReadyA = v.ordy;
    #1;
    checkOutput($sformatf("A%0d req_ready", idx), 32'(reqReadyA), 32'(v.expRdy));
    @(negedge clock);
    #1;
    checkOutput($sformatf("A%0d out_valid", idx), 32'(outValidA), 32'(v.expV));
    checkOutput($sformatf("A%0d out_data", idx), 32'(outDataA), 32'(v.expD));
    checkOutput($sformatf("A%0d out_id", idx), 32'(outIdA), 32'(v.expId));
  endtask

  // Same cycle pattern for the three-requester instance.
  task automatic applyStimulus3(input int idx, input logic nrst, input logic [2:0] rv,
                                input logic [23:0] data, input logic ordy,
                                input logic [2:0] expRdy, input logic expV,
                                input logic [7:0] expD, input logic [1:0] expId);
    @(posedge clock);
    nresetB   = nrst;
    flushB    = 1'b0;
    reqValidB = rv;
    reqDataB  = data;
    outReadyB = ordy;
    #1;
    checkOutput($sformatf("B%0d req_ready", idx), 32'(reqReadyB), 32'(expRdy));
    @(negedge clock);
    #1;
    checkOutput($sformatf("B%0d out_valid", idx), 32'(outValidB), 32'(expV));
    checkOutput($sformatf("B%0d out_data", idx), 32'(outDataB), 32'(expD));
    checkOutput($sformatf("B%0d out_id", idx), 32'(outIdB), 32'(expId));
  endtask

  initial begin
    nresetA = 1'b0; flushA = 1'b0; reqValidA = '0; reqDataA = '0; outReadyA = 1'b0;
    nresetB = 1'b0; flushB = 1'b0; reqValidB = '0; reqDataB = '0; outReadyB = 1'b0;

    //              nrst  fl    rv     d0     d1     ordy  rdy    v     data   id
    vecs[0]  = '{1'b0, 1'b0, 2'b11, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'b11, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, 8'hA5, 8'h00, 1'b1, 2'b01, 1'b1, 8'hA5, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'b11, 8'h11, 8'h22, 1'b1, 2'b10, 1'b1, 8'h22, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 2'b11, 8'h33, 8'h44, 1'b1, 2'b01, 1'b1, 8'h33, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'b11, 8'h55, 8'h66, 1'b1, 2'b10, 1'b1, 8'h66, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h66, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 2'b10, 8'h00, 8'h77, 1'b0, 2'b10, 1'b1, 8'h77, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 2'b11, 8'h88, 8'h99, 1'b0, 2'b00, 1'b1, 8'h77, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 2'b11, 8'h88, 8'h99, 1'b0, 2'b00, 1'b1, 8'h77, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 2'b11, 8'h5A, 8'hA5, 1'b0, 2'b00, 1'b1, 8'h77, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'b11, 8'h88, 8'h99, 1'b1, 2'b01, 1'b1, 8'h88, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 2'b11, 8'h01, 8'h02, 1'b1, 2'b00, 1'b0, 8'h88, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 2'b11, 8'hAA, 8'hBB, 1'b1, 2'b10, 1'b1, 8'hBB, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 2'b11, 8'h03, 8'h04, 1'b0, 2'b00, 1'b0, 8'hBB, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 2'b01, 8'hC3, 8'h00, 1'b0, 2'b01, 1'b1, 8'hC3, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 2'b11, 8'h05, 8'h06, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 2'b11, 8'hD1, 8'hE2, 1'b1, 2'b01, 1'b1, 8'hD1, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 2'b10, 8'h00, 8'hF0, 1'b1, 2'b10, 1'b1, 8'hF0, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 2'b01, 8'h0F, 8'h00, 1'b1, 2'b01, 1'b1, 8'h0F, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 2'b01, 8'h12, 8'h00, 1'b1, 2'b01, 1'b1, 8'h12, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 8'h12, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h12, 1'b0};

    $display("[TB] running %0d table rows on the 2-requester instance", 23);
    for (int i = 0; i < 23; i++) begin
      applyStimulus(i, vecs[i]);
    end

    $display("[TB] running pointer-wrap sequence on the 3-requester instance");
    //            nrst  rv      data {d2,d1,d0}          ordy  rdy     v     data   id
    applyStimulus3(0, 1'b0, 3'b000, {8'h00, 8'h00, 8'h00}, 1'b1, 3'b000, 1'b0, 8'h00, 2'd0);
    applyStimulus3(1, 1'b1, 3'b100, {8'hC2, 8'h00, 8'h00}, 1'b1, 3'b100, 1'b1, 8'hC2, 2'd2);
    applyStimulus3(2, 1'b1, 3'b101, {8'hC2, 8'h00, 8'hC0}, 1'b1, 3'b001, 1'b1, 8'hC0, 2'd0);
    applyStimulus3(3, 1'b1, 3'b101, {8'hD2, 8'h00, 8'hD0}, 1'b1, 3'b100, 1'b1, 8'hD2, 2'd2);
    applyStimulus3(4, 1'b1, 3'b110, {8'hE2, 8'hB1, 8'h00}, 1'b1, 3'b010, 1'b1, 8'hB1, 2'd1);
    applyStimulus3(5, 1'b1, 3'b011, {8'h00, 8'hA1, 8'hA0}, 1'b1, 3'b001, 1'b1, 8'hA0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, is the number of requesters; legal range 2..8.
REQ-002 Parameter DATA_W, default 32, is the payload width in bits.
REQ-003 Port clock, input, 1 bit: single clock; all state SHALL update on the negative edge.
REQ-004 Port nreset, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port flush, input, 1 bit: synchronous pipeline flush, active-high.
REQ-006 Port req_valid, input, NUM_REQ bits: per-requester valid.
REQ-007 Port req_data, input, NUM_REQ*DATA_W bits: per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 Port req_ready, output, NUM_REQ bits: per-requester ready.
REQ-009 Port out_valid, output, 1 bit: downstream valid (registered).
REQ-010 Port out_data, output, DATA_W bits: downstream payload (registered).
REQ-011 Port out_id, output, $clog2(NUM_REQ) bits: index of the requester that sourced out_data (registered).
REQ-012 Port out_ready, input, 1 bit: downstream ready.

Function
REQ-013 A transfer on requester i SHALL occur when req_valid[i] and req_ready[i] are both 1 at a clock edge; a downstream transfer SHALL occur when out_valid and out_ready are both 1.
REQ-014 The block SHALL hold one output slot with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 slot_free SHALL equal (!out_valid || out_ready) && !flush && nreset.
REQ-016 grant SHALL be combinational and one-hot or zero: the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
REQ-017 req_ready[i] SHALL equal grant[i] && slot_free; at most one req_ready bit SHALL be 1 per cycle.
REQ-018 req_ready SHALL never depend on req_data.
REQ-019 On an upstream transfer from requester i: out_data <= req_data[i], out_id <= i, out_valid <= 1, rr_ptr <= (i+1) mod NUM_REQ.
REQ-020 On a downstream transfer with no upstream transfer in the same cycle: out_valid <= 0; out_data and out_id SHALL hold.
REQ-021 Simultaneous downstream and upstream transfers SHALL replace the slot in the same cycle, sustaining 1 transfer/cycle.
REQ-022 When out_valid=1 and out_ready=0, out_valid, out_data and out_id SHALL hold stable and req_ready SHALL be all 0.
REQ-023 Latency from upstream transfer to out_valid SHALL be exactly 1 clock edge.
REQ-024 rr_ptr SHALL change only on an upstream transfer; with no req_valid asserted it SHALL hold.
REQ-025 Fairness: a requester holding req_valid=1 continuously SHALL be granted within NUM_REQ upstream transfers.
REQ-026 When NUM_REQ is not a power of two, the wrap of rr_ptr SHALL go from NUM_REQ-1 to 0.
REQ-027 Flush SHALL set out_valid <= 0 and block upstream transfers that cycle; out_data, out_id and rr_ptr SHALL hold.
REQ-028 Flush SHALL override a simultaneous upstream transfer; no payload SHALL be accepted during flush.

Reset
REQ-029 On a clock edge with nreset=0: out_valid=0, out_data=0, out_id=0, rr_ptr=0.
REQ-030 While nreset=0, req_ready SHALL be all 0.
REQ-031 Reset asserted while the slot is FULL SHALL discard the payload without a downstream transfer.
REQ-032 The first edge after nreset returns to 1 SHALL accept a transfer if req_valid and out_ready allow it.

Verification
REQ-033 Reset, then req_valid=2'b01, data0=0xA5, out_ready=1 -> req_ready=2'b01; next edge: out_valid=1, out_data=0xA5, out_id=0, rr_ptr=1.
REQ-034 Both requesters valid continuously, out_ready=1 -> out_id alternates 0,1,0,1 with out_valid=1 every cycle (full throughput).
REQ-035 Slot FULL with id 1, out_ready=0 for 3 cycles, both requesters valid -> req_ready=0 and out_* stable for 3 cycles; out_ready=1 -> requester 0 accepted on the same edge.
REQ-036 NUM_REQ=3, only requester 2 valid, then requesters 0 and 2 valid -> grant goes to 0 after 2 (rr_ptr wraps to 0).
REQ-037 Slot FULL, flush=1 with req_valid=2'b11 -> next edge out_valid=0, req_ready=0 during flush, rr_ptr unchanged.
REQ-038 Slot FULL, nreset=0 for one edge -> out_valid=0, out_data=0, out_id=0, rr_ptr=0; no downstream transfer is observed.
